mlp_sequencer: RTL
==================

# mlp_sequencer

Control FSM for the two-layer MLP MAC datapath (784→30→10). Sequences bias loading, W2 weight loading, layer-1 MAC, sigmoid write-back and layer-2 MAC. Drives every strobe and loop index the datapath consumes, and paces memory loads with a valid handshake. Sits between the top-level start/done interface and the `mac` datapath.

## Interface
- N_IN, 784: layer-1 inputs per hidden neuron
- N_HID, 30: hidden neurons
- N_OUT, 10: output neurons; must be even
- B_WORDS, 11: 32-bit words in the B1+B2 bias load
- W2_WORDS, 15: 32-bit words per W2 load (2·N_HID bytes)
- clk  in  1  clock
- rst_b  in  1  reset; asynchronous, active-low
- start  in  1  run request; sampled in IDLE only
- mem_valid  in  1  load word present on din buses this cycle
- fsm_state  out  4  current state encoding
- load_start, load_weight, layer1_start, sigmoid_start, layer2_start  out  1 each  datapath phase strobes
- read  out  1  image/W1 fetch request
- counter  out  15  load byte index / layer-1 index
- counter1  out  11  layer-1 input index, 0..N_IN
- counter2  out  5  hidden neuron index
- counter3  out  5  output neuron index
- counter2_1  out  5  layer-2 input index, 0..N_HID
- counter2_2  out  7  W2 buffer address
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse

## Operation
- States and encoding: IDLE=0, LOAD=1, LOADW=2, L1=3, SIG=4, L2=5, DONE=6. Exactly one phase strobe is high per state.
- **IDLE**
  - All outputs 0.
  - start=1 → LOAD.
- **LOAD** (load_start)
  - counter advances by 4 on each mem_valid cycle: 0,4,…,4·(B_WORDS-1).
  - Beat accepted at the last value → LOADW; counter clears.
  - read=0.
- **LOADW** (load_weight)
  - counter advances by 4 per mem_valid beat: 0,…,4·(W2_WORDS-1).
  - Last beat → L1 if the layer-1-done flag is clear, else → L2. counter clears.
- **L1** (layer1_start, read=1 while counter1<N_IN)
  - counter1 counts 0..N_IN; the value N_IN is the commit cycle. counter = counter1 zero-extended.
  - After commit: counter1 ← 0 and counter2 increments.
  - Commit with counter2=N_HID-1 → SIG; set layer-1-done flag.
- **SIG** (sigmoid_start)
  - counter2 sweeps 0..N_HID, i.e. N_HID+1 cycles, to cover the datapath's one-cycle-late write of B[counter2-1].
  - After the sweep → L2 with counter2=0.
- **L2** (layer2_start)
  - counter2_1 counts 0..N_HID; the value N_HID is the commit cycle.
  - counter2_2 = counter2_1 + (counter3[0] ? N_HID : 0) while counter2_1<N_HID; it holds during commit.
  - After commit: counter3 increments and counter2_1 clears.
  - Commit with counter3 odd and counter3<N_OUT-1 → LOADW to reload the next pair of W2 rows.
  - Commit with counter3=N_OUT-1 → DONE.
- **DONE**
  - done=1 for exactly one cycle, then → IDLE.
  - Clears the layer-1-done flag, counter2 and counter3.
- start while busy: ignored.
- mem_valid outside LOAD/LOADW: ignored.

## Timing
- Reset: state IDLE; all counters, strobes, the flag, busy and done are 0. Reset asserted mid-run aborts immediately with no completion pulse.
- All outputs are registered. Strobes and indices change on the same edge as the state change.
- The start→LOAD transition takes 1 cycle.
- A LOAD/LOADW beat with mem_valid=0 holds the state and counter; there is no timeout.
- With mem_valid tied high, phase lengths are:
  - LOAD: B_WORDS cycles
  - LOADW: W2_WORDS cycles
  - L1: N_HID·(N_IN+1) cycles
  - SIG: N_HID+1 cycles
  - L2: N_OUT·(N_HID+1) cycles, plus (N_OUT/2-1)·W2_WORDS reload cycles
- With defaults, done is high in cycle 23977, counting the first LOAD cycle as 0.
- Index arithmetic: all indices are unsigned; the largest counter2_2 value is 2·N_HID-1=59.

## Structure
- Shared package `mlp_pkg`:
  - state enum and its encoding
  - default N_IN/N_HID/N_OUT/B_WORDS/W2_WORDS
  - counter width constants
- Sub-module `mlp_loop_counter`: a generic nested inner/outer counter with enable, inner terminal value, an inner-wrap pulse and an outer-last flag. Instantiated for L1 (counter1/counter2) and L2 (counter2_1/counter3).

## Test plan
- Reset then start with mem_valid=1 → fsm_state sequence 0,1,2,3,4,5,2,5,…,6,0; done pulses once at cycle 23977; busy is high throughout.
- mem_valid toggled 1,0 every cycle in LOAD → counter steps 0,0,4,4,…; LOAD lasts 22 cycles; values end at 40.
- L1 boundary → counter1 reaches 784 for exactly one cycle per neuron, then 0 with counter2+1; after neuron 29 the next state is SIG.
- L2 addressing → at counter3=1, counter2_2 runs 30..59; after counter3=1 commits, LOADW is entered with 15 beats, then L2 resumes at counter3=2 with counter2_2=0.
- start pulses during L1 and DONE → no restart and no second done; start in the cycle after done begins a new run.
- rst_b dropped mid-L2 → all outputs 0 asynchronously; a restart runs the full sequence, with the layer-1 flag shown cleared by L1 being executed again.

Source files
------------

// File: rtl/mlp_pkg.sv
// Shared types and constants for the MLP control sequencer.
package mlp_pkg;

    // Default network shape: 784 inputs, 30 hidden neurons, 10 outputs.
    localparam int unsigned N_IN_DEF     = 784;
    localparam int unsigned N_HID_DEF    = 30;
    localparam int unsigned N_OUT_DEF    = 10;
    localparam int unsigned B_WORDS_DEF  = 11;
    localparam int unsigned W2_WORDS_DEF = 15;

    // Output widths seen by the datapath.
    localparam int unsigned STATE_W = 4;
    localparam int unsigned CNT_W   = 15;
    localparam int unsigned CNT1_W  = 11;
    localparam int unsigned CNT2_W  = 5;
    localparam int unsigned CNT3_W  = 5;
    localparam int unsigned CNT21_W = 5;
    localparam int unsigned CNT22_W = 7;

    typedef enum logic [STATE_W-1:0] {
        StIdle  = 4'd0,
        StLoad  = 4'd1,
        StLoadW = 4'd2,
        StL1    = 4'd3,
        StSig   = 4'd4,
        StL2    = 4'd5,
        StDone  = 4'd6
    } state_e;

endpackage

// File: rtl/mlp_sequencer_if.sv
// Control interface between the sequencer (master) and the MAC datapath / top level (slave).
interface mlp_sequencer_if;
    import mlp_pkg::*;

    logic                start;
    logic                mem_valid;
    logic [STATE_W-1:0]  fsm_state;
    logic                load_start;
    logic                load_weight;
    logic                layer1_start;
    logic                sigmoid_start;
    logic                layer2_start;
    logic                read;
    logic [CNT_W-1:0]    counter;
    logic [CNT1_W-1:0]   counter1;
    logic [CNT2_W-1:0]   counter2;
    logic [CNT3_W-1:0]   counter3;
    logic [CNT21_W-1:0]  counter2_1;
    logic [CNT22_W-1:0]  counter2_2;
    logic                busy;
    logic                done;

    modport master (
        input  start, mem_valid,
        output fsm_state, load_start, load_weight, layer1_start, sigmoid_start, layer2_start,
        output read, counter, counter1, counter2, counter3, counter2_1, counter2_2, busy, done
    );

    modport slave (
        output start, mem_valid,
        input  fsm_state, load_start, load_weight, layer1_start, sigmoid_start, layer2_start,
        input  read, counter, counter1, counter2, counter3, counter2_1, counter2_2, busy, done
    );

endinterface

// File: rtl/mlp_loop_counter.sv
// Nested inner/outer loop counter. The inner index runs 0..inner_term_i; reaching the
// terminal value on an enabled cycle wraps it to 0 and bumps the outer index.
module mlp_loop_counter #(
    parameter int unsigned InnerW = 11,
    parameter int unsigned OuterW = 5
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              en_i,
    input  logic              clr_i,
    input  logic [InnerW-1:0] inner_term_i,
    input  logic [OuterW-1:0] outer_last_i,
    output logic [InnerW-1:0] inner_o,
    output logic [InnerW-1:0] inner_nxt_o,
    output logic [OuterW-1:0] outer_o,
    output logic [OuterW-1:0] outer_nxt_o,
    output logic              wrap_o,
    output logic              last_o
);

    logic [InnerW-1:0] inner_q, inner_d;
    logic [OuterW-1:0] outer_q, outer_d;

    // Next index values; clear wins over counting.
    always_comb begin
        wrap_o  = en_i && (inner_q == inner_term_i);
        last_o  = (outer_q == outer_last_i);
        inner_d = inner_q;
        outer_d = outer_q;
        if (clr_i) begin
            inner_d = '0;
            outer_d = '0;
        end else if (wrap_o) begin
            inner_d = '0;
            outer_d = outer_q + OuterW'(1);
        end else if (en_i) begin
            inner_d = inner_q + InnerW'(1);
        end
    end

    // Index registers.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            inner_q <= '0;
            outer_q <= '0;
        end else begin
            inner_q <= inner_d;
            outer_q <= outer_d;
        end
    end

    assign inner_o     = inner_q;
    assign outer_o     = outer_q;
    assign inner_nxt_o = inner_d;
    assign outer_nxt_o = outer_d;

endmodule

// File: rtl/mlp_sequencer.sv
// Control FSM for the two-layer MLP MAC datapath. Every output is a register loaded from
// next-state values, so strobes and indices move on the same edge as the state.
module mlp_sequencer
    import mlp_pkg::*;
#(
    parameter int unsigned N_IN     = N_IN_DEF,
    parameter int unsigned N_HID    = N_HID_DEF,
    parameter int unsigned N_OUT    = N_OUT_DEF,
    parameter int unsigned B_WORDS  = B_WORDS_DEF,
    parameter int unsigned W2_WORDS = W2_WORDS_DEF
) (
    input logic             clk,
    input logic             rst_b,
    mlp_sequencer_if.master bus
);

    state_e               state_q, state_d;
    logic                 l1_done_q, l1_done_d;
    logic [CNT_W-1:0]     counter_q, counter_d;
    logic [CNT22_W-1:0]   c22_q, c22_d;
    logic [4:0]           strobe_q, strobe_d;
    logic                 read_q, read_d, busy_q, busy_d, done_q, done_d;

    logic                 l1_en, l1_clr, l1_wrap, l1_last;
    logic [CNT1_W-1:0]    l1_term, c1, c1_nxt;
    logic [CNT2_W-1:0]    l1_outer_last, c2, unused_c2_nxt;
    logic                 l2_en, l2_clr, l2_wrap, l2_last;
    logic [CNT21_W-1:0]   c21, c21_nxt;
    logic [CNT3_W-1:0]    c3, c3_nxt;
    logic                 load_last, loadw_last;

    assign load_last  = (counter_q == CNT_W'(4 * (B_WORDS - 1)));
    assign loadw_last = (counter_q == CNT_W'(4 * (W2_WORDS - 1)));

    // SIG reuses the layer-1 counter with an inner terminal of 0, so counter2 steps every cycle.
    assign l1_en         = (state_q == StL1) || (state_q == StSig);
    assign l1_term       = (state_q == StSig) ? '0 : CNT1_W'(N_IN);
    assign l1_outer_last = (state_q == StSig) ? CNT2_W'(N_HID) : CNT2_W'(N_HID - 1);
    assign l1_clr        = (l1_en && (state_d != state_q)) || (state_q == StDone);
    assign l2_en         = (state_q == StL2);
    assign l2_clr        = (state_q == StDone);

    mlp_loop_counter #(
        .InnerW(CNT1_W),
        .OuterW(CNT2_W)
    ) u_l1_cnt (
        .clk         (clk),
        .rst_b       (rst_b),
        .en_i        (l1_en),
        .clr_i       (l1_clr),
        .inner_term_i(l1_term),
        .outer_last_i(l1_outer_last),
        .inner_o     (c1),
        .inner_nxt_o (c1_nxt),
        .outer_o     (c2),
        .outer_nxt_o (unused_c2_nxt),
        .wrap_o      (l1_wrap),
        .last_o      (l1_last)
    );

    mlp_loop_counter #(
        .InnerW(CNT21_W),
        .OuterW(CNT3_W)
    ) u_l2_cnt (
        .clk         (clk),
        .rst_b       (rst_b),
        .en_i        (l2_en),
        .clr_i       (l2_clr),
        .inner_term_i(CNT21_W'(N_HID)),
        .outer_last_i(CNT3_W'(N_OUT - 1)),
        .inner_o     (c21),
        .inner_nxt_o (c21_nxt),
        .outer_o     (c3),
        .outer_nxt_o (c3_nxt),
        .wrap_o      (l2_wrap),
        .last_o      (l2_last)
    );

    // State transitions and the layer-1-done flag.
    always_comb begin
        state_d   = state_q;
        l1_done_d = l1_done_q;
        unique case (state_q)
            StIdle:  if (bus.start) state_d = StLoad;
            StLoad:  if (bus.mem_valid && load_last) state_d = StLoadW;
            StLoadW: if (bus.mem_valid && loadw_last) state_d = l1_done_q ? StL2 : StL1;
            StL1: begin
                if (l1_wrap && l1_last) begin
                    state_d   = StSig;
                    l1_done_d = 1'b1;
                end
            end
            StSig:   if (l1_last) state_d = StL2;
            StL2: begin
                // Each odd output neuron finishes a W2 row pair; fetch the next pair.
                if (l2_wrap) begin
                    if (l2_last) state_d = StDone;
                    else if (c3[0]) state_d = StLoadW;
                end
            end
            StDone: begin
                state_d   = StIdle;
                l1_done_d = 1'b0;
            end
            default: state_d = StIdle;
        endcase
    end

    // Registered output values, derived from the next state and next indices.
    always_comb begin
        counter_d = '0;
        c22_d     = c22_q;
        strobe_d  = '0;
        read_d    = (state_d == StL1) && (c1_nxt < CNT1_W'(N_IN));
        busy_d    = (state_d != StIdle);
        done_d    = (state_d == StDone);
        unique case (state_d)
            StLoad, StLoadW: begin
                if (state_d != state_q) counter_d = '0;
                else if (bus.mem_valid) counter_d = counter_q + CNT_W'(4);
                else counter_d = counter_q;
            end
            StL1:    counter_d = CNT_W'(c1_nxt);
            default: ;
        endcase
        unique case (state_d)
            StLoad:  strobe_d = 5'b10000;
            StLoadW: strobe_d = 5'b01000;
            StL1:    strobe_d = 5'b00100;
            StSig:   strobe_d = 5'b00010;
            StL2:    strobe_d = 5'b00001;
            default: ;
        endcase
        // W2 buffer holds two rows; odd neurons read the upper half. Held on commit cycles.
        if (state_d == StIdle) begin
            c22_d = '0;
        end else if ((state_d == StL2) && (c21_nxt < CNT21_W'(N_HID))) begin
            c22_d = CNT22_W'(c21_nxt) + (c3_nxt[0] ? CNT22_W'(N_HID) : '0);
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q   <= StIdle;
            l1_done_q <= 1'b0;
            counter_q <= '0;
            c22_q     <= '0;
            strobe_q  <= '0;
            read_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            l1_done_q <= l1_done_d;
            counter_q <= counter_d;
            c22_q     <= c22_d;
            strobe_q  <= strobe_d;
            read_q    <= read_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.fsm_state     = state_q;
    assign bus.load_start    = strobe_q[4];
    assign bus.load_weight   = strobe_q[3];
    assign bus.layer1_start  = strobe_q[2];
    assign bus.sigmoid_start = strobe_q[1];
    assign bus.layer2_start  = strobe_q[0];
    assign bus.read          = read_q;
    assign bus.counter       = counter_q;
    assign bus.counter1      = c1;
    assign bus.counter2      = c2;
    assign bus.counter3      = c3;
    assign bus.counter2_1    = c21;
    assign bus.counter2_2    = c22_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;

endmodule
